// File: rtl/hx8352_controller.sv
// HX8352-A TFT controller: panel reset, fixed init table, then continuous
// full-screen RGB565 streaming over a 16-bit 8080-style write bus.
module hx8352_controller #(
    parameter int unsigned RST_LOW_TICKS  = 1000,
    parameter int unsigned RST_WAIT_TICKS = 10000,
    parameter int unsigned INIT_DLY_TICKS = 5000,
    parameter int unsigned H_RES          = 240,
    parameter int unsigned V_RES          = 400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_1MHz,
    input  logic [15:0] data_in,
    output logic        busy,
    output logic        lcd_rs,
    output logic        lcd_wr,
    output logic        lcd_rd,
    output logic        lcd_rst,
    output logic        lcd_cs,
    output logic [15:0] data_bus,
    output logic        init_done
);

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned PIX_W   = 17;
    localparam int unsigned IDX_W   = 6;
    localparam int unsigned WIDX_W  = 4;
    localparam int unsigned PH_W    = 3;
    localparam int unsigned MAX_AB  = (RST_LOW_TICKS > RST_WAIT_TICKS) ? RST_LOW_TICKS : RST_WAIT_TICKS;
    localparam int unsigned CNT_MAX = (MAX_AB > INIT_DLY_TICKS) ? MAX_AB : INIT_DLY_TICKS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned PIX_LAST = H_RES * V_RES - 1;

    localparam logic [IDX_W-1:0]  ROM_LAST = IDX_W'(34);
    localparam logic [WIDX_W-1:0] WIN_CMD  = WIDX_W'(8);

    typedef enum logic [2:0] {
        RESET_LOW,
        RESET_WAIT,
        INIT,
        WINDOW,
        PIXELS
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [PH_W-1:0]     ph;
    logic [IDX_W-1:0]    idx;
    logic [WIDX_W-1:0]   widx;
    logic [PIX_W-1:0]    pix_cnt;

    logic [16:0]         rom_entry;
    logic [15:0]         win_entry;
    logic                is_delay;
    logic [7:0]          pair_reg;
    logic [7:0]          pair_val;

    // Init table entry: {delay flag, register, value}
    function automatic logic [16:0] init_rom(input logic [IDX_W-1:0] i);
        logic [16:0] e;
        case (i)
            6'd0:    e = 17'h0_8302;
            6'd1:    e = 17'h0_8503;
            6'd2:    e = 17'h0_8B93;
            6'd3:    e = 17'h0_8C93;
            6'd4:    e = 17'h0_9101;
            6'd5:    e = 17'h0_8300;
            6'd6:    e = 17'h1_0000;
            6'd7:    e = 17'h0_3EC4;
            6'd8:    e = 17'h0_3F44;
            6'd9:    e = 17'h0_1705;
            6'd10:   e = 17'h1_0000;
            6'd11:   e = 17'h0_2BF9;
            6'd12:   e = 17'h0_1B14;
            6'd13:   e = 17'h0_1A11;
            6'd14:   e = 17'h0_1C0D;
            6'd15:   e = 17'h0_1F42;
            6'd16:   e = 17'h1_0000;
            6'd17:   e = 17'h0_190A;
            6'd18:   e = 17'h0_191A;
            6'd19:   e = 17'h1_0000;
            6'd20:   e = 17'h0_1912;
            6'd21:   e = 17'h1_0000;
            6'd22:   e = 17'h0_1FD2;
            6'd23:   e = 17'h1_0000;
            6'd24:   e = 17'h0_1608;
            6'd25:   e = 17'h0_1801;
            6'd26:   e = 17'h0_0106;
            6'd27:   e = 17'h0_0000;
            6'd28:   e = 17'h0_3CC0;
            6'd29:   e = 17'h0_3D1C;
            6'd30:   e = 17'h0_3438;
            6'd31:   e = 17'h0_3538;
            6'd32:   e = 17'h0_2438;
            6'd33:   e = 17'h1_0000;
            6'd34:   e = 17'h0_243C;
            default: e = 17'h0_0000;
        endcase
        return e;
    endfunction

    // Full-screen window registers 02..09: {register, value}
    function automatic logic [15:0] win_rom(input logic [WIDX_W-1:0] i);
        logic [15:0] e;
        case (i)
            4'd0:    e = 16'h0200;
            4'd1:    e = 16'h0300;
            4'd2:    e = 16'h0400;
            4'd3:    e = 16'h05EF;
            4'd4:    e = 16'h0600;
            4'd5:    e = 16'h0700;
            4'd6:    e = 16'h0801;
            4'd7:    e = 16'h098F;
            default: e = 16'h0000;
        endcase
        return e;
    endfunction

    // Select the register pair currently being written
    always_comb begin
        rom_entry = init_rom(idx);
        win_entry = win_rom(widx);
        is_delay  = rom_entry[16];
        pair_reg  = rom_entry[15:8];
        pair_val  = rom_entry[7:0];
        if (state == WINDOW) begin
            pair_reg = win_entry[15:8];
            pair_val = win_entry[7:0];
        end
    end

    // Sequencer: every step advances only on a tick; all outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RESET_LOW;
            cnt       <= '0;
            ph        <= '0;
            idx       <= '0;
            widx      <= '0;
            pix_cnt   <= '0;
            busy      <= 1'b1;
            lcd_rs    <= 1'b0;
            lcd_wr    <= 1'b1;
            lcd_rd    <= 1'b1;
            lcd_rst   <= 1'b0;
            lcd_cs    <= 1'b1;
            data_bus  <= '0;
            init_done <= 1'b0;
        end else if (clk_1MHz) begin
            case (state)
                RESET_LOW: begin
                    if (cnt == CNT_W'(RST_LOW_TICKS - 1)) begin
                        cnt     <= '0;
                        lcd_rst <= 1'b1;
                        state   <= RESET_WAIT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESET_WAIT: begin
                    if (cnt == CNT_W'(RST_WAIT_TICKS - 1)) begin
                        cnt   <= '0;
                        idx   <= '0;
                        ph    <= '0;
                        state <= INIT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                INIT: begin
                    if (is_delay) begin
                        if (cnt == CNT_W'(INIT_DLY_TICKS - 1)) begin
                            cnt <= '0;
                            idx <= idx + IDX_W'(1);
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else begin
                        case (ph)
                            3'd0: begin
                                lcd_cs   <= 1'b0;
                                lcd_wr   <= 1'b0;
                                lcd_rs   <= 1'b0;
                                data_bus <= {8'h00, pair_reg};
                                ph       <= 3'd1;
                            end
                            3'd1: begin
                                lcd_wr <= 1'b1;
                                ph     <= 3'd2;
                            end
                            3'd2: begin
                                lcd_wr   <= 1'b0;
                                lcd_rs   <= 1'b1;
                                data_bus <= {8'h00, pair_val};
                                ph       <= 3'd3;
                            end
                            3'd3: begin
                                lcd_wr <= 1'b1;
                                ph     <= 3'd4;
                            end
                            default: begin
                                lcd_cs <= 1'b1;
                                ph     <= '0;
                                if (idx == ROM_LAST) begin
                                    init_done <= 1'b1;
                                    widx      <= '0;
                                    state     <= WINDOW;
                                end else begin
                                    idx <= idx + IDX_W'(1);
                                end
                            end
                        endcase
                    end
                end
                WINDOW: begin
                    if (widx == WIN_CMD) begin
                        // Memory write command; cs stays low into the pixel stream
                        if (ph == 3'd0) begin
                            lcd_cs   <= 1'b0;
                            lcd_wr   <= 1'b0;
                            lcd_rs   <= 1'b0;
                            data_bus <= 16'h0022;
                            ph       <= 3'd1;
                        end else begin
                            lcd_wr  <= 1'b1;
                            ph      <= '0;
                            pix_cnt <= '0;
                            state   <= PIXELS;
                        end
                    end else begin
                        case (ph)
                            3'd0: begin
                                lcd_cs   <= 1'b0;
                                lcd_wr   <= 1'b0;
                                lcd_rs   <= 1'b0;
                                data_bus <= {8'h00, pair_reg};
                                ph       <= 3'd1;
                            end
                            3'd1: begin
                                lcd_wr <= 1'b1;
                                ph     <= 3'd2;
                            end
                            3'd2: begin
                                lcd_wr   <= 1'b0;
                                lcd_rs   <= 1'b1;
                                data_bus <= {8'h00, pair_val};
                                ph       <= 3'd3;
                            end
                            3'd3: begin
                                lcd_wr <= 1'b1;
                                ph     <= 3'd4;
                            end
                            default: begin
                                lcd_cs <= 1'b1;
                                ph     <= '0;
                                widx   <= widx + WIDX_W'(1);
                            end
                        endcase
                    end
                end
                PIXELS: begin
                    case (ph)
                        3'd0: begin
                            busy <= 1'b0;
                            ph   <= 3'd1;
                        end
                        3'd1: begin
                            busy     <= 1'b1;
                            lcd_wr   <= 1'b0;
                            lcd_rs   <= 1'b1;
                            data_bus <= data_in;
                            ph       <= 3'd2;
                        end
                        3'd2: begin
                            lcd_wr <= 1'b1;
                            if (pix_cnt == PIX_W'(PIX_LAST)) begin
                                ph <= 3'd3;
                            end else begin
                                pix_cnt <= pix_cnt + PIX_W'(1);
                                ph      <= '0;
                            end
                        end
                        default: begin
                            lcd_cs  <= 1'b1;
                            pix_cnt <= '0;
                            widx    <= '0;
                            ph      <= '0;
                            state   <= WINDOW;
                        end
                    endcase
                end
                default: state <= RESET_LOW;
            endcase
        end
    end

endmodule

// File: tb/tb_hx8352_controller.sv
// Directed bench for hx8352_controller with shortened timing and a 4x3 frame.
module tb_hx8352_controller;

    localparam int unsigned T_LOW  = 100;
    localparam int unsigned T_WAIT = 200;
    localparam int unsigned T_DLY  = 50;
    localparam int unsigned H      = 4;
    localparam int unsigned V      = 3;
    localparam int unsigned NPIX   = H * V;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        clk_1MHz = 1'b1;
    logic [15:0] data_in  = 16'hF800;
    logic        busy, lcd_rs, lcd_wr, lcd_rd, lcd_rst, lcd_cs, init_done;
    logic [15:0] data_bus;

    hx8352_controller #(
        .RST_LOW_TICKS (T_LOW),
        .RST_WAIT_TICKS(T_WAIT),
        .INIT_DLY_TICKS(T_DLY),
        .H_RES         (H),
        .V_RES         (V)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_1MHz (clk_1MHz),
        .data_in  (data_in),
        .busy     (busy),
        .lcd_rs   (lcd_rs),
        .lcd_wr   (lcd_wr),
        .lcd_rd   (lcd_rd),
        .lcd_rst  (lcd_rst),
        .lcd_cs   (lcd_cs),
        .data_bus (data_bus),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc_n   = 0;
    logic [16:0] words[$];
    logic [16:0] lo_word = '0;
    int          lo_len  = 0;
    logic        prev_wr = 1'b1;
    int          proto_err = 0;
    int          cs_run  = 0;
    int          dly_gaps = 0;
    int          busy_lows = 0;
    int          pix_idx = 0;
    bit          pattern_mode = 1'b0;
    logic [7:0]  win_val [8] = '{8'h00, 8'h00, 8'h00, 8'hEF, 8'h00, 8'h00, 8'h01, 8'h8F};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] word_at(input int i);
        if (i < words.size()) return words[i];
        return 17'h1FFFF;
    endfunction

    task automatic mon_clear();
        words.delete();
        cyc_n = 0; lo_len = 0; prev_wr = 1'b1; proto_err = 0;
        cs_run = 0; dly_gaps = 0; busy_lows = 0; pix_idx = 0; pattern_mode = 1'b0;
        data_in = 16'hF800;
    endtask

    // One clock: advance, sample 1ns later, decode bus words and drive the pixel source
    task automatic cyc();
        logic was_low;
        was_low = !busy;
        @(posedge clk);
        #1;
        cyc_n++;
        if (was_low && clk_1MHz && pattern_mode) begin
            pix_idx++;
            data_in = 16'h1000 + 16'(pix_idx);
        end
        if (!busy) busy_lows++;
        if (!lcd_wr) begin
            lo_word = {lcd_rs, data_bus};
            lo_len++;
            if (lcd_cs) proto_err++;
        end else if (!prev_wr) begin
            words.push_back(lo_word);
            if (lo_len != 1) proto_err++;
            if (lcd_cs) proto_err++;
            lo_len = 0;
        end
        prev_wr = lcd_wr;
        if (lcd_cs) begin
            cs_run++;
        end else begin
            if (cs_run == int'(T_DLY + 1) && words.size() > 0 && !init_done) dly_gaps++;
            cs_run = 0;
        end
    endtask

    initial begin
        int          base;
        int          bad;
        int          changes;
        logic [22:0] snap;

        repeat (3) cyc();
        chk("rst_lcd_rst", lcd_rst, 0);
        chk("rst_lcd_cs", lcd_cs, 1);
        chk("rst_lcd_wr", lcd_wr, 1);
        chk("rst_lcd_rd", lcd_rd, 1);
        chk("rst_lcd_rs", lcd_rs, 0);
        chk("rst_data_bus", data_bus, 0);
        chk("rst_busy", busy, 1);
        chk("rst_init_done", init_done, 0);

        mon_clear();
        rst = 1'b1;
        for (int i = 0; i < 10 * T_LOW && !lcd_rst; i++) cyc();
        chk("rst_low_cycles", cyc_n, T_LOW);
        for (int i = 0; i < 10 * (T_LOW + T_WAIT) && lcd_cs; i++) cyc();
        chk("first_cs_cycle", cyc_n, T_LOW + T_WAIT + 1);
        chk("busy_before_init", busy_lows, 0);

        for (int i = 0; i < 50 && words.size() < 2; i++) cyc();
        chk("first_cmd", word_at(0), {1'b0, 16'h0083});
        chk("first_data", word_at(1), {1'b1, 16'h0002});

        for (int i = 0; i < 5000 && !init_done; i++) cyc();
        chk("init_done", init_done, 1);
        chk("init_words", words.size(), 56);
        chk("after_dly_cmd", word_at(12), {1'b0, 16'h003E});
        chk("after_dly_data", word_at(13), {1'b1, 16'h00C4});
        chk("last_init_cmd", word_at(54), {1'b0, 16'h0024});
        chk("last_init_data", word_at(55), {1'b1, 16'h003C});
        chk("delay_gaps", dly_gaps, 7);
        chk("busy_during_init", busy_lows, 0);

        // Frame 1: window setup, constant red pixels, next frame's first command
        base = 56;
        for (int i = 0; i < 2000 && words.size() < base + 30; i++) cyc();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("win_reg%0d", k), word_at(base + 2 * k), {1'b0, 8'h00, 8'(k + 2)});
            chk($sformatf("win_val%0d", k), word_at(base + 2 * k + 1), {1'b1, 8'h00, win_val[k]});
        end
        chk("mem_write_cmd", word_at(base + 16), {1'b0, 16'h0022});
        bad = 0;
        for (int i = 0; i < int'(NPIX); i++)
            if (word_at(base + 17 + i) !== {1'b1, 16'hF800}) bad++;
        chk("f1_pixel_mismatches", bad, 0);
        chk("f1_busy_pulses", busy_lows, NPIX);
        chk("f1_next_window", word_at(base + 29), {1'b0, 16'h0002});

        // Frame 2: incrementing source proves data_in is captured on the busy-low cycle
        pattern_mode = 1'b1;
        pix_idx      = 0;
        data_in      = 16'h1000;
        busy_lows    = 0;
        base         = base + 29;
        for (int i = 0; i < 2000 && words.size() < base + 30; i++) cyc();
        chk("f2_mem_write_cmd", word_at(base + 16), {1'b0, 16'h0022});
        bad = 0;
        for (int i = 0; i < int'(NPIX); i++)
            if (word_at(base + 17 + i) !== {1'b1, 16'h1000 + 16'(i)}) bad++;
        chk("f2_pixel_mismatches", bad, 0);
        chk("f2_busy_pulses", busy_lows, NPIX);
        chk("f2_next_window", word_at(base + 29), {1'b0, 16'h0002});
        chk("bus_protocol_errors", proto_err, 0);

        // Frame 3: stall ticks mid-frame, then reset asynchronously mid-pixel
        base = base + 29;
        for (int i = 0; i < 2000 && words.size() < base + 20; i++) cyc();
        chk("f3_reached_pixels", word_at(base + 17), {1'b1, 16'h1000 + 16'(NPIX)});
        snap = {busy, lcd_rs, lcd_wr, lcd_rd, lcd_rst, lcd_cs, data_bus, init_done};
        clk_1MHz = 1'b0;
        changes  = 0;
        repeat (50) begin
            cyc();
            if ({busy, lcd_rs, lcd_wr, lcd_rd, lcd_rst, lcd_cs, data_bus, init_done} !== snap) changes++;
        end
        chk("pause_no_change", changes, 0);
        clk_1MHz = 1'b1;
        cyc();
        cyc();
        #2 rst = 1'b0;
        #1;
        chk("async_lcd_rst", lcd_rst, 0);
        chk("async_lcd_cs", lcd_cs, 1);
        chk("async_init_done", init_done, 0);
        chk("async_busy", busy, 1);
        chk("async_lcd_wr", lcd_wr, 1);
        chk("async_data_bus", data_bus, 0);

        cyc();
        cyc();
        mon_clear();
        rst = 1'b1;
        for (int i = 0; i < 10 * T_LOW && !lcd_rst; i++) cyc();
        chk("rerun_rst_low_cycles", cyc_n, T_LOW);
        for (int i = 0; i < 10 * (T_LOW + T_WAIT) && words.size() < 2; i++) cyc();
        chk("rerun_first_cmd", word_at(0), {1'b0, 16'h0083});
        chk("rerun_first_data", word_at(1), {1'b1, 16'h0002});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
